// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes,
// FSM states, datapath select encodings and the ALU operation codes.
package mc_pkg;

    // RV32I base opcodes handled by the controller
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_JAL,
        S_JALR_ADR,
        S_JALR,
        S_BRANCH,
        S_LUI
    } state_t;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_BYTEEXT   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Which decoding rule the ALU decoder applies in the current state
    localparam logic [1:0] ALUCLS_ADD    = 2'b00;
    localparam logic [1:0] ALUCLS_R      = 2'b01;
    localparam logic [1:0] ALUCLS_I      = 2'b10;
    localparam logic [1:0] ALUCLS_BRANCH = 2'b11;

    // Immediate format implied by an opcode; unknown opcodes fall back to I
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OPC_STORE:           return IMM_S;
            OPC_BRANCH:          return IMM_B;
            OPC_JAL:             return IMM_J;
            OPC_LUI, OPC_AUIPC:  return IMM_U;
            default:             return IMM_I;
        endcase
    endfunction

    // True for every opcode the controller can execute
    function automatic logic is_supported(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the state's decoding rule plus funct3/funct7[5]
// onto an ALU operation code.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] i_alu_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_alu_control
);

    // Pure decode; address/link arithmetic states always add
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_class)
            ALUCLS_R, ALUCLS_I: begin
                case (i_funct3)
                    // SUB exists only for register-register ops; ADDI has no SUBI
                    3'b000:  o_alu_control = (i_alu_class == ALUCLS_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_control = ALU_SLL;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b011:  o_alu_control = ALU_SLTU;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_control = ALU_OR;
                    default: o_alu_control = ALU_AND;
                endcase
            end
            ALUCLS_BRANCH: begin
                case (i_funct3)
                    3'b000, 3'b001: o_alu_control = ALU_SUB;
                    3'b100, 3'b101: o_alu_control = ALU_SLT;
                    3'b110, 3'b111: o_alu_control = ALU_SLTU;
                    default:        o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multi-cycle RV32I core. Outputs are decoded
// combinationally from the state, the instruction register, Zero and
// MemReady so that stalls and branch decisions act in the same cycle.
module mc_controller
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  StoreSize,
    output logic [2:0]  ImmSrc,
    output logic [2:0]  ByteSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        IllegalInstr,
    output logic        InstrDone
);

    state_t      r_state;
    state_t      w_state_next;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic [1:0]  w_alu_class;
    logic        w_branch_taken;
    logic        w_branch_illegal;
    logic        w_unused_instr_bits;

    assign w_opcode   = Instr[6:0];
    assign w_funct3   = Instr[14:12];
    assign w_funct7b5 = Instr[30];

    // Register numbers and immediate bits belong to the datapath only
    assign w_unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    mc_aludec u_aludec (
        .i_alu_class   (w_alu_class),
        .i_funct3      (w_funct3),
        .i_funct7b5    (w_funct7b5),
        .o_alu_control (ALUControl)
    );

    // State register; reset wins over any pending wait
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Branch outcome: SUB gives Zero on equality, SLT/SLTU give Zero when not less
    always_comb begin
        w_branch_taken   = 1'b0;
        w_branch_illegal = 1'b0;
        case (w_funct3)
            3'b000:  w_branch_taken = Zero;
            3'b001:  w_branch_taken = ~Zero;
            3'b100:  w_branch_taken = ~Zero;
            3'b101:  w_branch_taken = Zero;
            3'b110:  w_branch_taken = ~Zero;
            3'b111:  w_branch_taken = Zero;
            default: w_branch_illegal = 1'b1;
        endcase
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:    if (MemReady) w_state_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OPC_LOAD, OPC_STORE: w_state_next = S_MEMADR;
                    OPC_OP:              w_state_next = S_EXEC_R;
                    OPC_OP_IMM:          w_state_next = S_EXEC_I;
                    OPC_JAL:             w_state_next = S_JAL;
                    OPC_JALR:            w_state_next = S_JALR_ADR;
                    OPC_BRANCH:          w_state_next = S_BRANCH;
                    OPC_LUI:             w_state_next = S_LUI;
                    OPC_AUIPC:           w_state_next = S_ALUWB;
                    default:             w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_next = (w_opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) w_state_next = S_MEMWB;
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWRITE: if (MemReady) w_state_next = S_FETCH;
            S_EXEC_R:   w_state_next = S_ALUWB;
            S_EXEC_I:   w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_JAL:      w_state_next = S_ALUWB;
            S_JALR_ADR: w_state_next = S_JALR;
            S_JALR:     w_state_next = S_ALUWB;
            S_BRANCH:   w_state_next = S_FETCH;
            S_LUI:      w_state_next = S_FETCH;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; anything not driven by a state stays 0
    always_comb begin
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        StoreSize    = 2'b00;
        ImmSrc       = imm_src_of(w_opcode);
        ByteSrc      = 3'b000;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ResultSrc    = RES_ALUOUT;
        IllegalInstr = 1'b0;
        InstrDone    = 1'b0;
        w_alu_class  = ALUCLS_ADD;
        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC when the fetch lands
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                // Speculative OldPC+imm in ALUOut serves branch/JAL/AUIPC
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (!is_supported(w_opcode)) begin
                    IllegalInstr = 1'b1;
                    InstrDone    = 1'b1;
                end
            end
            S_MEMADR, S_JALR_ADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                // Keep recomputing rs1+imm so ALUOut holds the address while stalled
                AdrSrc  = 1'b1;
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMWB: begin
                ResultSrc = RES_BYTEEXT;
                ByteSrc   = w_funct3;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                StoreSize = w_funct3[1:0];
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_IMM;
                InstrDone = MemReady;
            end
            S_EXEC_R: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_RS2;
                w_alu_class = ALUCLS_R;
            end
            S_EXEC_I: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_IMM;
                w_alu_class = ALUCLS_I;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_JAL, S_JALR: begin
                // Jump to the target in ALUOut while computing the link value
                PCWrite = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_BRANCH: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_RS2;
                w_alu_class  = ALUCLS_BRANCH;
                PCWrite      = w_branch_taken;
                IllegalInstr = w_branch_illegal;
                InstrDone    = 1'b1;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a hand-written vector table for
// the directed corner cases, then random instructions whose per-cycle
// control outputs come from an instruction-level sequence model.
module tb_mc_controller;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_SLT = 4'd8, A_SLTU = 4'd9;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic [1:0] ss;
        logic [2:0] imm;
        logic [2:0] bs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic [1:0] rs;
        logic       ill;
        logic       done;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        rdy;
        logic        zero;
        outs_t       exp;
    } vec_t;

    logic        CLK;
    logic        Reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic        IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]  StoreSize;
    logic [2:0]  ImmSrc, ByteSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]  ALUControl;
    logic        IllegalInstr, InstrDone;

    int n_cmp = 0;
    int n_err = 0;

    vec_t        dir[$];
    vec_t        rq[$];
    logic [31:0] cur_instr;
    outs_t       act;

    mc_controller dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Instr        (Instr),
        .Zero         (Zero),
        .MemReady     (MemReady),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .AdrSrc       (AdrSrc),
        .StoreSize    (StoreSize),
        .ImmSrc       (ImmSrc),
        .ByteSrc      (ByteSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ResultSrc    (ResultSrc),
        .IllegalInstr (IllegalInstr),
        .InstrDone    (InstrDone)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign act = {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, StoreSize, ImmSrc, ByteSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, IllegalInstr, InstrDone};

    function automatic outs_t e(input logic irw, input logic pcw, input logic rw, input logic mw,
                                input logic adr, input logic [1:0] ss, input logic [2:0] imm,
                                input logic [2:0] bs, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [3:0] alu, input logic [1:0] rs, input logic ill,
                                input logic done);
        outs_t o;
        o = {irw, pcw, rw, mw, adr, ss, imm, bs, sa, sb, alu, rs, ill, done};
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic rst, input logic [31:0] ins, input logic rdy, input logic z,
                       input outs_t ex);
        vec_t v;
        v.rst = rst; v.instr = ins; v.rdy = rdy; v.zero = z; v.exp = ex;
        dir.push_back(v);
    endtask

    task automatic push(input logic rdy, input logic z, input outs_t ex);
        vec_t v;
        v.rst = 1'b0; v.instr = cur_instr; v.rdy = rdy; v.zero = z; v.exp = ex;
        rq.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge, check mid-cycle
    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge CLK);
        Reset    = v.rst;
        Instr    = v.instr;
        MemReady = v.rdy;
        Zero     = v.zero;
        #1;
        n_cmp++;
        if (act !== v.exp) begin
            n_err++;
            $display("FAIL %s[%0d] instr=%h rdy=%0b zero=%0b: outputs got %h required %h",
                     tag, idx, v.instr, v.rdy, v.zero, act, v.exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] imm_fmt(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b1101111:             return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] op_r(input logic [2:0] f3, input logic b5);
        case (f3)
            3'd0:    return b5 ? A_SUB : A_ADD;
            3'd1:    return A_SLL;
            3'd2:    return A_SLT;
            3'd3:    return A_SLTU;
            3'd4:    return A_XOR;
            3'd5:    return b5 ? A_SRA : A_SRL;
            3'd6:    return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic [3:0] op_i(input logic [2:0] f3, input logic b5);
        return (f3 == 3'd0) ? A_ADD : op_r(f3, b5);
    endfunction

    // Expected cycle-by-cycle control for one instruction, with random stalls
    task automatic model_instr(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] im;
        logic       b5;
        logic       z;
        logic       taken;
        logic       ill;
        logic [3:0] bop;
        int         fw;
        int         dw;
        outs_t      aluwb;
        outs_t      mr;
        outs_t      jmp;
        outs_t      rs1imm;
        cur_instr = ins;
        op = ins[6:0];
        f3 = ins[14:12];
        b5 = ins[30];
        im = imm_fmt(op);
        fw = $urandom_range(0, 2);
        dw = $urandom_range(0, 3);
        aluwb  = e(0, 0, 1, 0, 0, 0, im, 0, 0, 0, A_ADD, 0, 0, 1);
        rs1imm = e(0, 0, 0, 0, 0, 0, im, 0, 2, 1, A_ADD, 0, 0, 0);
        jmp    = e(0, 1, 0, 0, 0, 0, im, 0, 1, 2, A_ADD, 0, 0, 0);
        repeat (fw) push(0, rb(), e(0, 0, 0, 0, 0, 0, im, 0, 0, 2, A_ADD, 2, 0, 0));
        push(1, rb(), e(1, 1, 0, 0, 0, 0, im, 0, 0, 2, A_ADD, 2, 0, 0));
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111:
                push(rb(), rb(), e(0, 0, 0, 0, 0, 0, im, 0, 1, 1, A_ADD, 0, 0, 0));
            default:
                push(rb(), rb(), e(0, 0, 0, 0, 0, 0, im, 0, 1, 1, A_ADD, 0, 1, 1));
        endcase
        case (op)
            7'b0000011: begin
                push(rb(), rb(), rs1imm);
                mr = e(0, 0, 0, 0, 1, 0, im, 0, 2, 1, A_ADD, 0, 0, 0);
                repeat (dw) push(0, rb(), mr);
                push(1, rb(), mr);
                push(rb(), rb(), e(0, 0, 1, 0, 0, 0, im, f3, 0, 0, A_ADD, 1, 0, 1));
            end
            7'b0100011: begin
                push(rb(), rb(), rs1imm);
                repeat (dw) push(0, rb(), e(0, 0, 0, 1, 1, f3[1:0], im, 0, 2, 1, A_ADD, 0, 0, 0));
                push(1, rb(), e(0, 0, 0, 1, 1, f3[1:0], im, 0, 2, 1, A_ADD, 0, 0, 1));
            end
            7'b0110011: begin
                push(rb(), rb(), e(0, 0, 0, 0, 0, 0, im, 0, 2, 0, op_r(f3, b5), 0, 0, 0));
                push(rb(), rb(), aluwb);
            end
            7'b0010011: begin
                push(rb(), rb(), e(0, 0, 0, 0, 0, 0, im, 0, 2, 1, op_i(f3, b5), 0, 0, 0));
                push(rb(), rb(), aluwb);
            end
            7'b0010111: push(rb(), rb(), aluwb);
            7'b0110111: push(rb(), rb(), e(0, 0, 1, 0, 0, 0, im, 0, 0, 0, A_ADD, 3, 0, 1));
            7'b1101111: begin
                push(rb(), rb(), jmp);
                push(rb(), rb(), aluwb);
            end
            7'b1100111: begin
                push(rb(), rb(), rs1imm);
                push(rb(), rb(), jmp);
                push(rb(), rb(), aluwb);
            end
            7'b1100011: begin
                z = rb();
                ill = 1'b0;
                // beq/bne: equal when rs1-rs2 is zero; blt/bge(u): less when slt result is nonzero
                case (f3)
                    3'd0:    begin bop = A_SUB;  taken = z;  end
                    3'd1:    begin bop = A_SUB;  taken = !z; end
                    3'd4:    begin bop = A_SLT;  taken = !z; end
                    3'd5:    begin bop = A_SLT;  taken = z;  end
                    3'd6:    begin bop = A_SLTU; taken = !z; end
                    3'd7:    begin bop = A_SLTU; taken = z;  end
                    default: begin bop = A_ADD;  taken = 1'b0; ill = 1'b1; end
                endcase
                push(rb(), z, e(0, taken, 0, 0, 0, 0, im, 0, 2, 0, bop, 0, ill, 1));
            end
            default: ;
        endcase
    endtask

    localparam logic [31:0] LW   = 32'h0000A183;
    localparam logic [31:0] ADDI = 32'h00A00093;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] SW   = 32'h0010A023;
    localparam logic [31:0] CUS  = 32'h0000000B;

    logic [6:0] ops [11];

    initial begin
        Reset = 1'b1; Instr = '0; Zero = 1'b0; MemReady = 1'b0;

        // Reset state: FETCH, memory not ready, no strobes
        add(1, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        add(1, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        // lw into MEMREAD, then reset for two cycles while still waiting
        add(0, LW, 1, 0, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(1, LW, 0, 0, e(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(1, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        // addi x1,x0,10
        add(0, ADDI, 1, 0, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, ADDI, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, A_ADD, 0, 0, 0));
        add(0, ADDI, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, ADDI, 0, 0, e(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 1));
        // beq taken
        add(0, BEQ, 1, 0, e(1, 1, 0, 0, 0, 0, 2, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, BEQ, 0, 0, e(0, 0, 0, 0, 0, 0, 2, 0, 1, 1, A_ADD, 0, 0, 0));
        add(0, BEQ, 0, 1, e(0, 1, 0, 0, 0, 0, 2, 0, 2, 0, A_SUB, 0, 0, 1));
        // beq not taken
        add(0, BEQ, 1, 1, e(1, 1, 0, 0, 0, 0, 2, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, BEQ, 0, 1, e(0, 0, 0, 0, 0, 0, 2, 0, 1, 1, A_ADD, 0, 0, 0));
        add(0, BEQ, 1, 0, e(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, A_SUB, 0, 0, 1));
        // lw with three wait cycles
        add(0, LW, 1, 0, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 1, e(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, LW, 1, 0, e(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, LW, 0, 0, e(0, 0, 1, 0, 0, 0, 0, 2, 0, 0, A_ADD, 1, 0, 1));
        // sw with one wait cycle
        add(0, SW, 1, 0, e(1, 1, 0, 0, 0, 0, 1, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, SW, 0, 0, e(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, A_ADD, 0, 0, 0));
        add(0, SW, 0, 0, e(0, 0, 0, 0, 0, 0, 1, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, SW, 0, 0, e(0, 0, 0, 1, 1, 2, 1, 0, 2, 1, A_ADD, 0, 0, 0));
        add(0, SW, 1, 0, e(0, 0, 0, 1, 1, 2, 1, 0, 2, 1, A_ADD, 0, 0, 1));
        add(0, SW, 0, 0, e(0, 0, 0, 0, 0, 0, 1, 0, 0, 2, A_ADD, 2, 0, 0));
        // unsupported custom opcode
        add(0, CUS, 1, 0, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));
        add(0, CUS, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, A_ADD, 0, 1, 1));
        add(0, CUS, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, A_ADD, 2, 0, 0));

        foreach (dir[i]) apply(dir[i], "dir", i);

        // Random instruction stream checked against the sequence model
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2]  = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6]  = 7'b1100111; ops[7] = 7'b0110111;
        ops[8] = 7'b0010111; ops[9] = 7'b0001011; ops[10] = 7'b1110011;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom();
            rq.delete();
            model_instr({r[31:7], ops[$urandom_range(0, 10)]});
            foreach (rq[i]) apply(rq[i], "rnd", n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Decodes the registered instruction (Instr) and the ALU Zero flag from the datapath.
- Each cycle, drives the datapath's enables, mux selects and ALUControl, plus the memory address select and write strobe.
- Adds a one-bit memory-ready handshake so instruction and data accesses can stall.

Parameters:
- RESET_STATE, S_FETCH, FSM state entered on Reset (kept as a parameter for debug builds).

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Instr  in  32  instruction register contents from the datapath
- Zero  in  1  ALU zero flag from the datapath, same-cycle combinational
- MemReady  in  1  memory has completed the current access this cycle
- IRWrite  out  1  instruction register / OldPC load enable
- PCWrite  out  1  PC load enable (PC <- Result)
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write strobe
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- StoreSize  out  2  funct3[1:0] of the store (byte/half/word)
- ImmSrc  out  3  immediate format: I=000, S=001, B=010, J=011, U=100
- ByteSrc  out  3  load extend select, equal to funct3
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUControl  out  4  ALU operation, encoding from the package
- ResultSrc  out  2  00 = ALUOut, 01 = ByteExt, 10 = ALUResult, 11 = ImmExt
- IllegalInstr  out  1  one-cycle pulse when an unsupported opcode is decoded
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- Reset: state <= RESET_STATE. All outputs are combinational from state and Instr (Moore/Mealy mix). Reset overrides every state, including mid-wait.
- Default value of every output in every state is 0. ImmSrc defaults to the format implied by the opcode.
- ALUOut is reloaded every cycle. Any state that reads ALUOut while waiting must keep the ALU driving the same operands.

State actions and transitions:
- FETCH: AdrSrc=0; ALUSrcA=00, ALUSrcB=10, ADD; ResultSrc=10. IRWrite and PCWrite are asserted only when MemReady=1; otherwise stay in FETCH. On MemReady=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD, producing OldPC+imm in ALUOut. Next state by opcode:
  - load/store -> MEMADR
  - OP -> EXEC_R
  - OP-IMM -> EXEC_I
  - JAL -> JAL
  - JALR -> JALR_ADR
  - BRANCH -> BRANCH
  - LUI -> LUI
  - AUIPC -> ALUWB
  - anything else -> FETCH with IllegalInstr=1 and InstrDone=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00, same ALU drive as MEMADR. Stay until MemReady=1, then -> MEMWB.
- MEMWB: ResultSrc=01, ByteSrc=funct3, RegWrite=1, InstrDone=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, StoreSize=funct3[1:0], same ALU drive as MEMADR. Hold until MemReady=1; then InstrDone=1 -> FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, op from funct3/funct7[5] -> ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, op from funct3. funct7[5] is honoured only for SRAI. -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1 -> FETCH.
- JAL: ResultSrc=00, PCWrite=1 (target from DECODE); ALUSrcA=01, ALUSrcB=10, ADD (OldPC+4 into ALUOut) -> ALUWB.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ADD -> JALR.
- JALR: same outputs as JAL -> ALUWB. Target bit 0 is not cleared; odd targets are unsupported.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00. PCWrite = taken, InstrDone=1 -> FETCH. Compare op and taken condition by funct3:
  - BEQ: SUB, taken when Zero=1
  - BNE: SUB, taken when Zero=0
  - BLT: SLT, taken when Zero=0
  - BGE: SLT, taken when Zero=1
  - BLTU: SLTU, taken when Zero=0
  - BGEU: SLTU, taken when Zero=1
  - funct3 010/011: IllegalInstr=1, not taken.
- LUI: ResultSrc=11, ImmSrc=U, RegWrite=1, InstrDone=1 -> FETCH.

Cycle counts:
- R/I/AUIPC/LUI: 4/4/3/3 cycles.
- Load/store: 5/4 cycles plus memory wait cycles.
- Branch: 3 cycles. JAL: 4. JALR: 5.
- rd=x0 writes are issued normally; the register file discards them.

Decomposition:
- Package mc_pkg holds:
  - opcode constants (LOAD, STORE, OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC)
  - state enum
  - ImmSrc, ALUSrcA/B and ResultSrc encodings
  - ALUControl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- One sub-module, mc_aludec: combinational mapping of (state class, funct3, funct7[5]) to ALUControl.

Test Plan:
- Reset held for 2 cycles in MEMREAD -> next state FETCH; IRWrite=0, PCWrite=0, MemWrite=0 during reset.
- Instr=0x00A00093 (addi x1,x0,10), MemReady=1 -> states FETCH, DECODE, EXEC_I, ALUWB. ALUControl=0000 in EXEC_I; RegWrite=1 only in ALUWB; InstrDone pulses once.
- Instr=0x00208463 (beq x1,x2,8) with Zero=1 -> PCWrite=1 in BRANCH. Same instruction with Zero=0 -> PCWrite=0.
- Instr=0x0000A183 (lw x3,0(x1)), MemReady low for 3 cycles in MEMREAD -> MEMREAD held for 4 cycles with AdrSrc=1 and stable ALU drive; MEMWB asserts RegWrite with ByteSrc=010.
- Instr=0x0010A023 (sw), MemReady low for 1 cycle -> MemWrite high for 2 cycles, StoreSize=10, then FETCH.
- Instr=0x0000000B (custom opcode) -> IllegalInstr pulses in DECODE; next state FETCH; no RegWrite or PCWrite outside FETCH.
